// File: rtl/ppu_timing_gen.sv
// ppu_timing_gen: PPU scanline/dot timing, blanking decode, tile-fetch phase, vblank flag and NMI request
// Ports: PPUCLK clock; RST sync active-high reset; RENDER_EN, NMI_EN, STATUS_RD ($2002 read pulse) inputs;
// DOT/LINE counters; VISIBLE/HBLANK/FETCH_ACTIVE/FETCH_PHASE/FRAME_START decoded from the current dot;
// VBLANK status flag, NMI = VBLANK & NMI_EN, ODD_FRAME toggling on every frame wrap.
// Build option PPU_ODD_SKIP_EN: on odd frames with rendering on, the last pre-render dot is skipped.
module ppu_timing_gen #(
  parameter int DOTS_PER_LINE   = 341,
  parameter int LINES_PER_FRAME = 262,
  parameter int VIS_DOTS        = 256,
  parameter int VIS_LINES       = 240,
  parameter int VBLANK_LINE     = 241,
  parameter int PRERENDER_LINE  = 261,
  parameter int CNT_W           = 9
) (
  input  logic             PPUCLK,
  input  logic             RST,
  input  logic             RENDER_EN,
  input  logic             NMI_EN,
  input  logic             STATUS_RD,
  output logic [CNT_W-1:0] DOT,
  output logic [CNT_W-1:0] LINE,
  output logic             VISIBLE,
  output logic             HBLANK,
  output logic             VBLANK,
  output logic             NMI,
  output logic             FETCH_ACTIVE,
  output logic [2:0]       FETCH_PHASE,
  output logic             ODD_FRAME,
  output logic             FRAME_START
);
  localparam logic [CNT_W-1:0] DOT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DOT_LAST  = CNT_W'(DOTS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(LINES_PER_FRAME - 1);
  localparam logic [CNT_W-1:0] VIS_D     = CNT_W'(VIS_DOTS);
  localparam logic [CNT_W-1:0] VIS_L     = CNT_W'(VIS_LINES);
  localparam logic [CNT_W-1:0] VBL       = CNT_W'(VBLANK_LINE);
  localparam logic [CNT_W-1:0] PRE       = CNT_W'(PRERENDER_LINE);
  localparam logic [CNT_W-1:0] FET_LO    = CNT_W'(DOTS_PER_LINE - 20);
  localparam logic [CNT_W-1:0] FET_HI    = CNT_W'(DOTS_PER_LINE - 5);
`ifdef PPU_ODD_SKIP_EN
  localparam logic [CNT_W-1:0] DOT_SKIP  = CNT_W'(DOTS_PER_LINE - 2);
`endif
  logic [CNT_W-1:0] dot_q, dot_d, line_q, line_d;
  logic             vblank_q, vblank_d, odd_q, odd_d;
  logic             skip, line_end, frame_end, render_line, fetch_win;
  always_comb begin
`ifdef PPU_ODD_SKIP_EN
    skip = line_q == PRE && odd_q && RENDER_EN && dot_q == DOT_SKIP;
`else
    // rendering has no effect on frame length in this build
    skip = RENDER_EN & 1'b0;
`endif
    line_end  = dot_q == DOT_LAST || skip;
    frame_end = line_end && line_q == LINE_LAST;
    dot_d     = line_end ? '0 : dot_q + 1'b1;
    line_d    = frame_end ? '0 : line_end ? line_q + 1'b1 : line_q;
    odd_d     = odd_q ^ frame_end;
    // a $2002 read on the set edge wins, suppressing the flag (and NMI) for this frame
    vblank_d  = STATUS_RD ? 1'b0 :
                (line_d == VBL && dot_d == DOT_ONE) ? 1'b1 :
                (line_d == PRE && dot_d == DOT_ONE) ? 1'b0 : vblank_q;
  end
  always_ff @(posedge PPUCLK) begin
    if (RST) begin
      dot_q    <= '0;
      line_q   <= PRE;
      vblank_q <= 1'b0;
      odd_q    <= 1'b0;
    end else begin
      dot_q    <= dot_d;
      line_q   <= line_d;
      vblank_q <= vblank_d;
      odd_q    <= odd_d;
    end
  end
  always_comb begin
    render_line  = line_q < VIS_L || line_q == PRE;
    fetch_win    = (dot_q >= DOT_ONE && dot_q <= VIS_D) || (dot_q >= FET_LO && dot_q <= FET_HI);
    VISIBLE      = line_q < VIS_L && dot_q >= DOT_ONE && dot_q <= VIS_D;
    HBLANK       = dot_q == '0 || dot_q > VIS_D;
    FETCH_ACTIVE = render_line && fetch_win;
    FETCH_PHASE  = FETCH_ACTIVE ? 3'(dot_q - DOT_ONE) : 3'd0;
    FRAME_START  = line_q == '0 && dot_q == '0;
  end
  assign DOT       = dot_q;
  assign LINE      = line_q;
  assign VBLANK    = vblank_q;
  assign NMI       = vblank_q & NMI_EN;
  assign ODD_FRAME = odd_q;
endmodule
